// File: rtl/axi_llc_scrub_sched.sv
// Background ECC scrub scheduler for the LLC data ways.
// Walks (way, granule) pairs round-robin, emits paced one-hot scrub triggers,
// skips disabled ways and counts corrected/uncorrectable events.
// Optional feature: define AXI_LLC_SCRUB_IRQ_EN to add a sticky uncorrectable irq
// (irq_o) with its clear input (irq_clr_i).
module axi_llc_scrub_sched #(
    parameter int unsigned NumWays       = 8,
    parameter int unsigned NumGran       = 4,
    parameter int unsigned IntervalWidth = 16,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           en_i,
    input  logic [IntervalWidth-1:0]                       interval_i,
    input  logic [NumWays-1:0]                             way_mask_i,
    input  logic                                           clr_cnt_i,
    output logic [NumWays*NumGran-1:0]                     scrub_trigger_o,
    input  logic [NumWays*NumGran-1:0]                     scrubber_fix_i,
    input  logic [NumWays*NumGran-1:0]                     scrub_uncorrectable_i,
    output logic [CntWidth-1:0]                            fix_cnt_o,
    output logic [CntWidth-1:0]                            uncorr_cnt_o,
    output logic [((NumWays > 1) ? $clog2(NumWays) : 1)-1:0] cur_way_o,
    output logic [((NumGran > 1) ? $clog2(NumGran) : 1)-1:0] cur_gran_o,
    output logic                                           busy_o,
    output logic                                           sweep_done_o
`ifdef AXI_LLC_SCRUB_IRQ_EN
    ,
    input  logic                                           irq_clr_i,
    output logic                                           irq_o
`endif
);

    localparam int unsigned WayW = (NumWays > 1) ? $clog2(NumWays) : 1;
    localparam int unsigned GranW = (NumGran > 1) ? $clog2(NumGran) : 1;
    localparam int unsigned TotW = NumWays * NumGran;
    localparam int unsigned IdxW = (TotW > 1) ? $clog2(TotW) : 1;
    localparam int unsigned SumW = CntWidth + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_TRIG = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IntervalWidth-1:0]   r_cnt;
    logic [WayW-1:0]            r_way;
    logic [GranW-1:0]           r_gran;
    logic [TotW-1:0]            r_trig;
    logic                       r_busy;
    logic                       r_sweep;
    logic [CntWidth-1:0]        r_fix_cnt;
    logic [CntWidth-1:0]        r_unc_cnt;

    logic                       w_active;
    logic                       w_gran_wrap;
    logic [GranW-1:0]           w_gran_nxt;
    logic [WayW-1:0]            w_next_way;
    logic [IdxW-1:0]            w_trig_idx;
    logic [TotW-1:0]            w_trig_d;
    logic                       w_busy_d;
    logic                       w_sweep_d;
    logic [SumW-1:0]            w_fix_sum;
    logic [SumW-1:0]            w_unc_sum;

    assign w_active    = en_i & (|way_mask_i);
    assign w_gran_wrap = (r_gran == GranW'(NumGran - 1));
    assign w_gran_nxt  = w_gran_wrap ? '0 : r_gran + GranW'(1);
    assign w_trig_idx  = IdxW'(r_way) * IdxW'(NumGran) + IdxW'(r_gran);

    // Next enabled way strictly above r_way with wraparound; r_way itself is the last candidate
    always_comb begin
        int unsigned v_idx;
        logic        v_found;
        w_next_way = r_way;
        v_found    = 1'b0;
        v_idx      = 0;
        for (int unsigned i = 1; i <= NumWays; i++) begin
            v_idx = (32'(r_way) + i) % NumWays;
            if (!v_found && way_mask_i[WayW'(v_idx)]) begin
                w_next_way = WayW'(v_idx);
                v_found    = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_active) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_active)          w_state_nxt = S_IDLE;
                else if (r_cnt == '0)   w_state_nxt = S_TRIG;
            end
            S_TRIG:  w_state_nxt = w_active ? S_WAIT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs, computed one cycle ahead so the output registers line up with the state
    always_comb begin
        w_trig_d  = '0;
        w_busy_d  = (w_state_nxt != S_IDLE);
        w_sweep_d = 1'b0;
        if (w_state_nxt == S_TRIG && way_mask_i[r_way]) begin
            w_trig_d[w_trig_idx] = 1'b1;
        end
        if (r_state == S_TRIG && w_gran_wrap && (w_next_way <= r_way)) begin
            w_sweep_d = 1'b1;
        end
    end

    // Interval counter, pointers and registered FSM outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_way   <= '0;
            r_gran  <= '0;
            r_trig  <= '0;
            r_busy  <= 1'b0;
            r_sweep <= 1'b0;
        end else begin
            r_trig  <= w_trig_d;
            r_busy  <= w_busy_d;
            r_sweep <= w_sweep_d;
            if (w_state_nxt == S_WAIT && r_state != S_WAIT) begin
                r_cnt <= interval_i;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - IntervalWidth'(1);
            end
            if (r_state == S_TRIG) begin
                r_gran <= w_gran_nxt;
                if (w_gran_wrap) r_way <= w_next_way;
            end
        end
    end

    assign w_fix_sum = {1'b0, r_fix_cnt} + SumW'($countones(scrubber_fix_i));
    assign w_unc_sum = {1'b0, r_unc_cnt} + SumW'($countones(scrub_uncorrectable_i));

    // Saturating event counters; a clear drops that cycle's events
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            r_fix_cnt <= '0;
            r_unc_cnt <= '0;
        end else begin
            r_fix_cnt <= w_fix_sum[CntWidth] ? '1 : w_fix_sum[CntWidth-1:0];
            r_unc_cnt <= w_unc_sum[CntWidth] ? '1 : w_unc_sum[CntWidth-1:0];
        end
    end

`ifdef AXI_LLC_SCRUB_IRQ_EN
    logic r_irq;

    // Sticky uncorrectable interrupt; a new event beats a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else if (|scrub_uncorrectable_i) begin
            r_irq <= 1'b1;
        end else if (irq_clr_i) begin
            r_irq <= 1'b0;
        end
    end

    assign irq_o = r_irq;
`endif

    assign scrub_trigger_o = r_trig;
    assign busy_o          = r_busy;
    assign sweep_done_o    = r_sweep;
    assign cur_way_o       = r_way;
    assign cur_gran_o      = r_gran;
    assign fix_cnt_o       = r_fix_cnt;
    assign uncorr_cnt_o    = r_unc_cnt;

endmodule

// File: tb/tb_axi_llc_scrub_sched.sv
// Directed testbench for axi_llc_scrub_sched (8 ways x 4 granules).
// Define AXI_LLC_SCRUB_IRQ_EN to also exercise the irq ports.
module tb_axi_llc_scrub_sched;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [15:0] interval_i;
    logic [7:0]  way_mask_i;
    logic        clr_cnt_i;
    logic [31:0] scrub_trigger_o;
    logic [31:0] scrubber_fix_i;
    logic [31:0] scrub_uncorrectable_i;
    logic [15:0] fix_cnt_o;
    logic [15:0] uncorr_cnt_o;
    logic [2:0]  cur_way_o;
    logic [1:0]  cur_gran_o;
    logic        busy_o;
    logic        sweep_done_o;
`ifdef AXI_LLC_SCRUB_IRQ_EN
    logic        irq_clr_i;
    logic        irq_o;
`endif

    int checks   = 0;
    int failures = 0;

    axi_llc_scrub_sched dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .en_i                  (en_i),
        .interval_i            (interval_i),
        .way_mask_i            (way_mask_i),
        .clr_cnt_i             (clr_cnt_i),
        .scrub_trigger_o       (scrub_trigger_o),
        .scrubber_fix_i        (scrubber_fix_i),
        .scrub_uncorrectable_i (scrub_uncorrectable_i),
        .fix_cnt_o             (fix_cnt_o),
        .uncorr_cnt_o          (uncorr_cnt_o),
        .cur_way_o             (cur_way_o),
        .cur_gran_o            (cur_gran_o),
        .busy_o                (busy_o),
        .sweep_done_o          (sweep_done_o)
`ifdef AXI_LLC_SCRUB_IRQ_EN
        ,
        .irq_clr_i             (irq_clr_i),
        .irq_o                 (irq_o)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; observe 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        en_i                  = 1'b0;
        interval_i            = 16'd0;
        way_mask_i            = 8'h00;
        clr_cnt_i             = 1'b0;
        scrubber_fix_i        = 32'h0;
        scrub_uncorrectable_i = 32'h0;
`ifdef AXI_LLC_SCRUB_IRQ_EN
        irq_clr_i             = 1'b0;
`endif
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        en_i                  = 1'b1;
        way_mask_i            = 8'hFF;
        scrubber_fix_i        = 32'hFFFF_FFFF;
        scrub_uncorrectable_i = 32'hFFFF_FFFF;
        rst_i                 = 1'b1;
        tick();
        tick();
        checks++;
        if (scrub_trigger_o !== 32'h0 || busy_o !== 1'b0 || sweep_done_o !== 1'b0 ||
            fix_cnt_o !== 16'h0 || uncorr_cnt_o !== 16'h0 || cur_way_o !== 3'd0 || cur_gran_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: trig=%h busy=%b sweep=%b fix=%h unc=%h way=%0d gran=%0d required all 0",
                     scrub_trigger_o, busy_o, sweep_done_o, fix_cnt_o, uncorr_cnt_o, cur_way_o, cur_gran_o);
        end
`ifdef AXI_LLC_SCRUB_IRQ_EN
        checks++;
        if (irq_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b required 0", irq_o);
        end
`endif
        quiet_inputs();
        rst_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || scrub_trigger_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b trig=%h required 0/0", busy_o, scrub_trigger_o);
        end
    endtask

    // interval=3, all ways: bit n at edge 5+5n, sweep pulse one edge after bit 31
    task automatic test_pacing();
        logic [31:0] exp_trig;
        logic        exp_sweep;
        do_reset();
        way_mask_i = 8'hFF;
        interval_i = 16'd3;
        en_i       = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            tick();
            exp_trig = 32'h0;
            if (k >= 5 && ((k - 5) % 5) == 0) exp_trig = 32'd1 << (((k - 5) / 5) % 32);
            exp_sweep = (k == 161);
            checks++;
            if (scrub_trigger_o !== exp_trig) begin
                failures++;
                $display("FAIL pacing_trig k=%0d: got %h required %h", k, scrub_trigger_o, exp_trig);
            end
            checks++;
            if (sweep_done_o !== exp_sweep) begin
                failures++;
                $display("FAIL pacing_sweep k=%0d: got %b required %b", k, sweep_done_o, exp_sweep);
            end
            if (k == 1) begin
                checks++;
                if (busy_o !== 1'b1) begin
                    failures++;
                    $display("FAIL pacing_busy: got %b required 1", busy_o);
                end
            end
        end
        en_i = 1'b0;
    endtask

    // mask ways 0 and 2, interval=0: period 2, bits 0,1,2,3,8,9,10,11,0
    task automatic test_skip();
        int          seq [9] = '{0, 1, 2, 3, 8, 9, 10, 11, 0};
        logic [31:0] exp_trig;
        do_reset();
        way_mask_i = 8'b0000_0101;
        interval_i = 16'd0;
        en_i       = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_trig = 32'h0;
            if (k >= 2 && (k % 2) == 0) exp_trig = 32'd1 << seq[k / 2 - 1];
            checks++;
            if (scrub_trigger_o !== exp_trig) begin
                failures++;
                $display("FAIL skip_trig k=%0d: got %h required %h", k, scrub_trigger_o, exp_trig);
            end
            checks++;
            if (sweep_done_o !== (k == 17)) begin
                failures++;
                $display("FAIL skip_sweep k=%0d: got %b required %b", k, sweep_done_o, (k == 17));
            end
        end
        en_i = 1'b0;
    endtask

    // Only way 3 enabled, pointer starts on disabled way 0: four silent TRIGs, then 12..15, wrap onto itself
    task automatic test_single_way();
        logic [31:0] exp_trig;
        int          n;
        do_reset();
        way_mask_i = 8'b0000_1000;
        interval_i = 16'd0;
        en_i       = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_trig = 32'h0;
            if (k >= 2 && (k % 2) == 0) begin
                n = k / 2 - 1;
                if (n >= 4) exp_trig = 32'd1 << (12 + ((n - 4) % 4));
            end
            checks++;
            if (scrub_trigger_o !== exp_trig) begin
                failures++;
                $display("FAIL single_trig k=%0d: got %h required %h", k, scrub_trigger_o, exp_trig);
            end
            checks++;
            if (sweep_done_o !== (k == 17)) begin
                failures++;
                $display("FAIL single_sweep k=%0d: got %b required %b", k, sweep_done_o, (k == 17));
            end
            if (k == 9) begin
                checks++;
                if (cur_way_o !== 3'd3 || cur_gran_o !== 2'd0) begin
                    failures++;
                    $display("FAIL single_ptr: got way=%0d gran=%0d required 3/0", cur_way_o, cur_gran_o);
                end
            end
        end
        en_i = 1'b0;
    endtask

    // interval=10: drop enable in WAIT at pointer (2,1), then resume with bit 9
    task automatic test_disable();
        logic [31:0] exp_trig;
        do_reset();
        way_mask_i = 8'hFF;
        interval_i = 16'd10;
        en_i       = 1'b1;
        for (int k = 1; k <= 112; k++) begin
            tick();
            exp_trig = 32'h0;
            if (k >= 12 && ((k - 12) % 12) == 0) exp_trig = 32'd1 << ((k - 12) / 12);
            checks++;
            if (scrub_trigger_o !== exp_trig) begin
                failures++;
                $display("FAIL dis_run_trig k=%0d: got %h required %h", k, scrub_trigger_o, exp_trig);
            end
        end
        en_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || cur_way_o !== 3'd2 || cur_gran_o !== 2'd1) begin
            failures++;
            $display("FAIL dis_idle: busy=%b way=%0d gran=%0d required 0/2/1", busy_o, cur_way_o, cur_gran_o);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (scrub_trigger_o !== 32'h0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL dis_quiet k=%0d: trig=%h busy=%b required 0/0", k, scrub_trigger_o, busy_o);
            end
        end
        en_i = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            exp_trig = (j == 12) ? 32'h0000_0200 : 32'h0;
            checks++;
            if (scrub_trigger_o !== exp_trig) begin
                failures++;
                $display("FAIL dis_resume j=%0d: got %h required %h", j, scrub_trigger_o, exp_trig);
            end
        end
        en_i = 1'b0;
    endtask

    task automatic test_counters();
        do_reset();
        scrubber_fix_i = 32'h0000_0111;
        tick();
        scrubber_fix_i = 32'h0;
        checks++;
        if (fix_cnt_o !== 16'd3 || uncorr_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL cnt_fix3: fix=%0d unc=%0d required 3/0", fix_cnt_o, uncorr_cnt_o);
        end
        scrub_uncorrectable_i = 32'h8000_000F;
        tick();
        scrub_uncorrectable_i = 32'h0;
        tick();
        checks++;
        if (fix_cnt_o !== 16'd3 || uncorr_cnt_o !== 16'd5) begin
            failures++;
            $display("FAIL cnt_unc5: fix=%0d unc=%0d required 3/5", fix_cnt_o, uncorr_cnt_o);
        end
        clr_cnt_i             = 1'b1;
        scrubber_fix_i        = 32'h0000_0001;
        scrub_uncorrectable_i = 32'h0000_0002;
        tick();
        clr_cnt_i             = 1'b0;
        scrub_uncorrectable_i = 32'h0;
        checks++;
        if (fix_cnt_o !== 16'd0 || uncorr_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL cnt_clr_wins: fix=%0d unc=%0d required 0/0", fix_cnt_o, uncorr_cnt_o);
        end
        // 2047 cycles of 32 events = 0xFFE0, then 30 more = 0xFFFE
        scrubber_fix_i = 32'hFFFF_FFFF;
        repeat (2047) tick();
        scrubber_fix_i = 32'h3FFF_FFFF;
        tick();
        checks++;
        if (fix_cnt_o !== 16'hFFFE) begin
            failures++;
            $display("FAIL cnt_preload: got %h required fffe", fix_cnt_o);
        end
        scrubber_fix_i = 32'h0000_0003;
        tick();
        checks++;
        if (fix_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_sat_exact: got %h required ffff", fix_cnt_o);
        end
        scrubber_fix_i = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (fix_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_sat_hold: got %h required ffff", fix_cnt_o);
        end
        clr_cnt_i      = 1'b1;
        scrubber_fix_i = 32'h0000_0010;
        tick();
        clr_cnt_i      = 1'b0;
        scrubber_fix_i = 32'h0000_0001;
        checks++;
        if (fix_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL cnt_clr_sat: got %h required 0", fix_cnt_o);
        end
        tick();
        scrubber_fix_i = 32'h0;
        checks++;
        if (fix_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL cnt_after_clr: got %0d required 1", fix_cnt_o);
        end
    endtask

`ifdef AXI_LLC_SCRUB_IRQ_EN
    task automatic test_irq();
        do_reset();
        scrub_uncorrectable_i = 32'h0000_0020;
        tick();
        scrub_uncorrectable_i = 32'h0;
        checks++;
        if (irq_o !== 1'b1) begin
            failures++;
            $display("FAIL irq_set: got %b required 1", irq_o);
        end
        tick();
        checks++;
        if (irq_o !== 1'b1) begin
            failures++;
            $display("FAIL irq_sticky: got %b required 1", irq_o);
        end
        irq_clr_i             = 1'b1;
        scrub_uncorrectable_i = 32'h0000_0020;
        tick();
        scrub_uncorrectable_i = 32'h0;
        checks++;
        if (irq_o !== 1'b1) begin
            failures++;
            $display("FAIL irq_set_wins: got %b required 1", irq_o);
        end
        tick();
        irq_clr_i = 1'b0;
        checks++;
        if (irq_o !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear: got %b required 0", irq_o);
        end
    endtask
`endif

    initial begin
        quiet_inputs();
        rst_i = 1'b1;
        test_reset();
        test_pacing();
        test_skip();
        test_single_way();
        test_disable();
        test_counters();
`ifdef AXI_LLC_SCRUB_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
